enemy_wave_scheduler: RTL

Sequences the pool of enemy unit slots for the battlefield. It issues one-cycle spawn commands to free slots and picks each enemy's type from a wave-scaled LFSR. It generates the shared move/damage strobes that pace every unit, and tracks wave progress. It sits between the top-level game controller and the array of enemy unit instances, whose `dead` outputs it consumes.

---
 rtl/enemy_wave_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler: paces enemy units with move/damage strobes and issues
// one-hot spawn commands to free slots, wave by wave.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                game running; low freezes the tick counter
//   slot_dead             per-slot free flag from the enemy units
//   spawn_req, spawn_type one-cycle one-hot spawn command and the enemy type
//   move_scen, damage_scen one-cycle strobes, damage trails move by a cycle
//   wave_num, wave_done   current wave (saturates at 15), wave-cleared pulse
module enemy_wave_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int TICK_DIV   = 25_000_000,
  parameter int SPAWN_GAP  = 3,
  parameter int WAVE_SIZE  = 6,
  parameter int WAVE_PAUSE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] slot_dead,
  output logic [NUM_SLOTS-1:0] spawn_req,
  output logic [1:0]           spawn_type,
  output logic                 move_scen,
  output logic                 damage_scen,
  output logic [3:0]           wave_num,
  output logic                 wave_done
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(SPAWN_GAP + 1);
  localparam int PW = $clog2(WAVE_PAUSE + 1);
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_SPAWN, S_HOLD, S_DRAIN, S_PAUSE} state_t;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [PW-1:0]        pause_cnt;
  logic [7:0]           spawned;
  logic [7:0]           lfsr;
  logic                 hold2;
  logic                 tick;
  logic [NUM_SLOTS-1:0] sel;
  logic [1:0]           base_type;
  logic [1:0]           typ;
  assign tick = enable && tick_cnt == TW'(TICK_DIV - 1);
  // x & -x isolates the lowest set bit: lowest-index free slot wins
  assign sel = slot_dead & (~slot_dead + NUM_SLOTS'(1));
  assign base_type = lfsr[1:0] == 2'b00 ? 2'b01 : lfsr[1:0];
  // the strongest type is withheld during the first two waves
  assign typ = (wave_num < 4'd2 && base_type == 2'b11) ? 2'b10 : base_type;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt    <= '0;
      lfsr        <= 8'hA5;
      move_scen   <= 1'b0;
      damage_scen <= 1'b0;
    end else begin
      if (enable) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      move_scen   <= tick;
      damage_scen <= move_scen;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      pause_cnt  <= '0;
      spawned    <= '0;
      hold2      <= 1'b0;
      spawn_req  <= '0;
      spawn_type <= '0;
      wave_num   <= '0;
      wave_done  <= 1'b0;
    end else begin
      wave_done <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          state   <= S_GAP;
          gap_cnt <= '0;
        end
        S_GAP: if (tick) begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(SPAWN_GAP - 1)) state <= S_SPAWN;
        end
        S_SPAWN: if (enable && |slot_dead) begin
          spawn_req  <= sel;
          spawn_type <= typ;
          spawned    <= spawned + 8'd1;
          hold2      <= 1'b0;
          state      <= S_HOLD;
        end
        // two cycles so the freshly spawned unit has dropped its dead flag
        S_HOLD: begin
          spawn_req <= '0;
          hold2     <= 1'b1;
          if (hold2) begin
            state   <= spawned == 8'(WAVE_SIZE) ? S_DRAIN : S_GAP;
            gap_cnt <= '0;
          end
        end
        S_DRAIN: if (&slot_dead) begin
          wave_done <= 1'b1;
          wave_num  <= wave_num == 4'd15 ? 4'd15 : wave_num + 4'd1;
          spawned   <= '0;
          pause_cnt <= '0;
          state     <= S_PAUSE;
        end
        S_PAUSE: if (tick) begin
          pause_cnt <= pause_cnt + 1'b1;
          if (pause_cnt == PW'(WAVE_PAUSE - 1)) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
